// File: rtl/segasys1_sprcoll_ram.sv
`default_nettype none
// ============================================================================
//  Module   : segasys1_sprcoll_ram
//  Purpose  : Sprite collision capture memory (1<<AW x 1) with event FIFO,
//             clear sweep, CPU poll/clear port and sticky summary flags.
//  Revision : 1.0 - initial release
// ============================================================================
module segasys1_sprcoll_ram #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 10
) (
    input  logic          VCLKx4,
    input  logic          RESETn,
    input  logic          sprcoll,
    input  logic [AW-1:0] sprcoll_ad,
    input  logic [AW-1:0] cpu_ad,
    input  logic          cpu_cs_ram,
    input  logic          cpu_cs_sum,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    output logic [7:0]    cpu_dout,
    input  logic          clr_all,
    output logic          busy,
    output logic          coll_sum,
    output logic          ovf
);

    localparam int              c_PW    = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]   c_LAST  = {AW{1'b1}};
    localparam logic [c_PW:0]   c_DEPTH = (c_PW+1)'(FIFO_DEPTH);

    logic              r_mem [0:(1<<AW)-1];
    logic [AW-1:0]     r_fifo [0:FIFO_DEPTH-1];
    logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_PW:0]     r_count;
    logic              r_busy;
    logic [AW-1:0]     r_sweep_ad;
    logic              r_coll_sum, r_ovf;
    logic [7:0]        r_dout;

    logic          w_ram_sel, w_sum_sel, w_cpu_ram;
    logic          w_full, w_empty, w_pop, w_push, w_drop;
    logic          w_we, w_wbit;
    logic [AW-1:0] w_wad;

    // Selecting both regions at once is treated as selecting neither.
    assign w_ram_sel = cpu_cs_ram & ~cpu_cs_sum;
    assign w_sum_sel = cpu_cs_sum & ~cpu_cs_ram;
    assign w_cpu_ram = w_ram_sel & (cpu_rd | cpu_wr);

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~r_busy & ~w_cpu_ram & ~w_empty & ~clr_all;
    assign w_push  = sprcoll & ~clr_all & (~w_full | w_pop);
    assign w_drop  = sprcoll & ~clr_all & w_full & ~w_pop;

    // Single memory write port: sweep, then CPU clear, then event set.
    always_comb begin
        w_we   = 1'b0;
        w_wad  = r_sweep_ad;
        w_wbit = 1'b0;
        if (r_busy) begin
            w_we = 1'b1;
        end else if (w_ram_sel && cpu_wr) begin
            w_we  = 1'b1;
            w_wad = cpu_ad;
        end else if (w_pop) begin
            w_we   = 1'b1;
            w_wad  = r_fifo[r_rd_ptr];
            w_wbit = 1'b1;
        end
    end

    always_ff @(posedge VCLKx4) begin
        if (w_we)
            r_mem[w_wad] <= w_wbit;
        if (w_push)
            r_fifo[r_wr_ptr] <= sprcoll_ad;
    end

    always_ff @(posedge VCLKx4 or negedge RESETn) begin
        if (!RESETn) begin
            r_busy     <= 1'b1;
            r_sweep_ad <= '0;
            r_coll_sum <= 1'b0;
            r_ovf      <= 1'b0;
            r_dout     <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (clr_all) begin
                r_busy     <= 1'b1;
                r_sweep_ad <= '0;
            end else if (r_busy) begin
                if (r_sweep_ad == c_LAST)
                    r_busy <= 1'b0;
                r_sweep_ad <= r_sweep_ad + AW'(1);
            end

            if (clr_all) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + c_PW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                r_count <= r_count + (c_PW+1)'(w_push) - (c_PW+1)'(w_pop);
            end

            // Clears are applied first so a coincident set wins.
            if (clr_all || (w_sum_sel && cpu_wr))
                r_coll_sum <= 1'b0;
            if (w_pop)
                r_coll_sum <= 1'b1;
            if (w_sum_sel && cpu_wr)
                r_ovf <= 1'b0;
            if (w_drop)
                r_ovf <= 1'b1;

            if (cpu_rd && w_ram_sel)
                r_dout <= r_busy ? 8'hFE : {7'h7F, r_mem[cpu_ad]};
            else if (cpu_rd && w_sum_sel)
                r_dout <= {6'b0, r_ovf, r_coll_sum};
        end
    end

    assign cpu_dout = r_dout;
    assign busy     = r_busy;
    assign coll_sum = r_coll_sum;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_segasys1_sprcoll_ram.sv
`default_nettype none
// Testbench for segasys1_sprcoll_ram: directed scenarios plus random traffic,
// checked every cycle against a queue/array reference model.
module tb_segasys1_sprcoll_ram;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int NWORD = 1 << AW;

    logic          clk = 1'b0;
    logic          RESETn = 1'b1;
    logic          sprcoll = 1'b0;
    logic [AW-1:0] sprcoll_ad = '0;
    logic [AW-1:0] cpu_ad = '0;
    logic          cpu_cs_ram = 1'b0, cpu_cs_sum = 1'b0;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [7:0]    cpu_dout;
    logic          clr_all = 1'b0;
    logic          busy, coll_sum, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    segasys1_sprcoll_ram #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .VCLKx4(clk), .RESETn(RESETn),
        .sprcoll(sprcoll), .sprcoll_ad(sprcoll_ad),
        .cpu_ad(cpu_ad), .cpu_cs_ram(cpu_cs_ram), .cpu_cs_sum(cpu_cs_sum),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .clr_all(clr_all), .busy(busy), .coll_sum(coll_sum), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   m_mem [0:NWORD-1];
    int   m_q [$];
    int   m_left;          // sweep cycles remaining; busy while nonzero
    bit   m_sum, m_ovf;
    logic [7:0] m_dout;
    bit   rs, ss, mb, cram, pop;

    initial foreach (m_mem[i]) m_mem[i] = 1'b0;

    always @(negedge clk) begin
        if (!RESETn) begin
            m_q.delete();
            m_left = NWORD;
            m_sum  = 1'b0;
            m_ovf  = 1'b0;
            m_dout = 8'h00;
        end
        chk("busy",     {31'b0, busy},     {31'b0, (m_left > 0)});
        chk("coll_sum", {31'b0, coll_sum}, {31'b0, m_sum});
        chk("ovf",      {31'b0, ovf},      {31'b0, m_ovf});
        chk("cpu_dout", {24'b0, cpu_dout}, {24'b0, m_dout});
        if (RESETn) begin
            rs   = cpu_cs_ram && !cpu_cs_sum;
            ss   = cpu_cs_sum && !cpu_cs_ram;
            mb   = (m_left > 0);
            cram = rs && (cpu_rd || cpu_wr);
            pop  = !mb && !cram && (m_q.size() > 0) && !clr_all;
            if (cpu_rd && rs)      m_dout = mb ? 8'hFE : {7'h7F, m_mem[cpu_ad]};
            else if (cpu_rd && ss) m_dout = {6'b0, m_ovf, m_sum};
            if (mb)                 m_mem[NWORD - m_left] = 1'b0;
            else if (rs && cpu_wr)  m_mem[cpu_ad] = 1'b0;
            else if (pop) begin
                m_mem[m_q[0]] = 1'b1;
                void'(m_q.pop_front());
            end
            if (ss && cpu_wr) begin
                m_sum = 1'b0;
                m_ovf = 1'b0;
            end
            if (clr_all) begin
                m_sum = 1'b0;
                m_q.delete();
                m_left = NWORD;
            end else begin
                if (mb) m_left--;
                if (pop) m_sum = 1'b1;
                if (sprcoll) begin
                    if (m_q.size() < DEPTH) m_q.push_back(int'(sprcoll_ad));
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd_ram(input logic [AW-1:0] a, output logic [7:0] d);
        cpu_cs_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = a;
        step();
        cpu_cs_ram = 1'b0; cpu_rd = 1'b0;
        d = cpu_dout;
    endtask

    task automatic rd_sum(output logic [7:0] d);
        cpu_cs_sum = 1'b1; cpu_rd = 1'b1;
        step();
        cpu_cs_sum = 1'b0; cpu_rd = 1'b0;
        d = cpu_dout;
    endtask

    task automatic wr_ram(input logic [AW-1:0] a);
        cpu_cs_ram = 1'b1; cpu_wr = 1'b1; cpu_ad = a;
        step();
        cpu_cs_ram = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic wr_sum();
        cpu_cs_sum = 1'b1; cpu_wr = 1'b1;
        step();
        cpu_cs_sum = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic pulse(input logic [AW-1:0] a);
        sprcoll = 1'b1; sprcoll_ad = a;
        step();
        sprcoll = 1'b0;
    endtask

    task automatic clear_pulse();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
    endtask

    // counts cycles until busy falls, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1100) begin
            step();
            n++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] d;
        int n;
        int last_pulse;
        int hog;

        #2 RESETn = 1'b0;
        idle(3);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_dout", {24'b0, cpu_dout}, 32'h00);
        chk("rst_sum",  {30'b0, ovf, coll_sum}, 32'd0);
        RESETn = 1'b1;

        // initial sweep with reads while busy
        rd_ram(10'h155, d);  chk("busy_ram_rd", {24'b0, d}, 32'hFE);
        rd_sum(d);           chk("busy_sum_rd", {24'b0, d}, 32'h00);
        count_busy(n);
        chk("sweep_len", 32'(n + 2), 32'd1024);

        // single event
        pulse(10'h2A3);
        step();
        chk("sum_set", {31'b0, coll_sum}, 32'd1);
        rd_ram(10'h2A3, d);  chk("rd_2A3", {24'b0, d}, 32'hFF);
        rd_ram(10'h2A2, d);  chk("rd_2A2", {24'b0, d}, 32'hFE);
        rd_sum(d);           chk("rd_sum1", {24'b0, d}, 32'h01);

        // CPU hogs the port: 4 queued, 5th dropped
        cpu_cs_ram = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h000;
        for (int i = 0; i < 5; i++) begin
            pulse(10'(16 + i));
            step();
        end
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        cpu_cs_ram = 1'b0; cpu_rd = 1'b0;
        idle(6);
        for (int i = 0; i < 5; i++) begin
            rd_ram(10'(16 + i), d);
            chk("hog_rd", {24'b0, d}, (i < 4) ? 32'hFF : 32'hFE);
        end

        // clear and set to the same address in one cycle: set wins
        wr_ram(10'h2A3);
        rd_ram(10'h2A3, d);  chk("clr_2A3", {24'b0, d}, 32'hFE);
        sprcoll = 1'b1; sprcoll_ad = 10'h2A3;
        cpu_cs_ram = 1'b1; cpu_wr = 1'b1; cpu_ad = 10'h2A3;
        step();
        sprcoll = 1'b0; cpu_cs_ram = 1'b0; cpu_wr = 1'b0;
        idle(2);
        rd_ram(10'h2A3, d);  chk("set_wins", {24'b0, d}, 32'hFF);

        // summary write coincident with pop
        wr_sum();
        pulse(10'h100);
        cpu_cs_sum = 1'b1; cpu_wr = 1'b1;
        step();
        cpu_cs_sum = 1'b0; cpu_wr = 1'b0;
        chk("sumwr_pop_sum", {31'b0, coll_sum}, 32'd1);
        chk("sumwr_pop_ovf", {31'b0, ovf}, 32'd0);

        // restart sweep midway, event during sweep lands afterwards
        clear_pulse();
        idle(512);
        clear_pulse();
        pulse(10'h3FF);
        count_busy(n);
        chk("restart_len", 32'(n + 1), 32'd1024);
        idle(2);
        chk("post_sweep_sum", {31'b0, coll_sum}, 32'd1);
        rd_ram(10'h3FF, d);  chk("rd_3FF", {24'b0, d}, 32'hFF);

        // async reset with FIFO holding events mid-sweep
        clear_pulse();
        for (int i = 0; i < 5; i++) begin
            pulse(10'(8'h50 + i));
            step();
        end
        chk("pre_rst_ovf", {31'b0, ovf}, 32'd1);
        #2 RESETn = 1'b0;
        #1;
        chk("arst_dout", {24'b0, cpu_dout}, 32'h00);
        chk("arst_busy", {31'b0, busy}, 32'd1);
        chk("arst_flags", {30'b0, ovf, coll_sum}, 32'd0);
        idle(3);
        RESETn = 1'b1;
        count_busy(n);
        chk("rst_sweep_len", 32'(n), 32'd1024);
        idle(4);
        rd_ram(10'h050, d);  chk("flushed", {24'b0, d}, 32'hFE);
        chk("flushed_sum", {31'b0, coll_sum}, 32'd0);

        // random traffic
        last_pulse = 0;
        hog = 0;
        for (int i = 0; i < 4000; i++) begin
            int op;
            clr_all = ($urandom_range(0, 599) == 0);
            sprcoll = 1'b0;
            if (!clr_all && (i - last_pulse) >= 2 && $urandom_range(0, 99) < 45) begin
                sprcoll    = 1'b1;
                sprcoll_ad = 10'h3E0 | 10'($urandom_range(0, 31));
                last_pulse = i;
            end
            cpu_cs_ram = 1'b0; cpu_cs_sum = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
            cpu_ad = 10'h3E0 | 10'($urandom_range(0, 31));
            if (hog > 0) begin
                hog--;
                cpu_cs_ram = 1'b1; cpu_rd = 1'b1;
            end else begin
                op = $urandom_range(0, 19);
                case (op)
                    5, 6:    begin cpu_cs_ram = 1'b1; cpu_rd = 1'b1; end
                    7:       begin cpu_cs_ram = 1'b1; cpu_wr = 1'b1; end
                    8, 9:    begin cpu_cs_sum = 1'b1; cpu_rd = 1'b1; end
                    10:      begin cpu_cs_sum = 1'b1; cpu_wr = 1'b1; end
                    11:      hog = $urandom_range(4, 14);
                    default: ;
                endcase
            end
            step();
        end
        clr_all = 1'b0; sprcoll = 1'b0;
        cpu_cs_ram = 1'b0; cpu_cs_sum = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
